alu_rr_arbiter: RTL and testbench

- Shares one instance of the team's 4-op ALU between two requesters (e.g. an EX-stage issue port and a multi-cycle helper unit).
- Arbitrates round-robin, computes in the ALU, and holds the result in one output register with a valid/ready handshake and backpressure.
- Keeps a per-requester count of served operations for debug and performance tracking.

---
 rtl/alu_rr_arbiter_if.sv | 46 ++++
 rtl/alu_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_alu_rr_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rr_arbiter_if.sv
// Handshake bundle between two ALU requesters, the shared ALU arbiter and its result consumer.
// Latency: none; wires only.
// Backpressure: req*_ready and resp_ready carry the stall information; valid must never depend on ready.
interface alu_rr_arbiter_if #(
    parameter int WIDTH = 32
);
    // requester 0
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_op;

    // requester 1
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_op;

    // result channel
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic             resp_id;

    // requesters plus result consumer
    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  resp_valid, resp_data, resp_id,
        output resp_ready
    );

    // the arbiter itself
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output resp_valid, resp_data, resp_id,
        input  resp_ready
    );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin share of one 4-op ALU between two requesters, with a single registered result slot.
// Latency: 1 cycle from accept to resp_valid; 1 op/cycle sustained while resp_ready is high.
// Backpressure: a full, undrained result slot drops both req*_ready; prio/counters/result then freeze.
module alu_rr_arbiter #(
    parameter int WIDTH = 32,   // the ALU is 32-bit only
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    alu_rr_arbiter_if.slave  bus,
    output logic [CNT_W-1:0] served0,
    output logic [CNT_W-1:0] served1
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // state: priority pointer (0 favours requester 0) and the result slot
    logic             prio;
    logic             resp_valid_q;
    logic [WIDTH-1:0] resp_data_q;
    logic             resp_id_q;

    // combinational arbitration and operand selection
    logic             can_accept;
    logic             any_req;
    logic             grant;
    logic             xfer;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] alu_y;

    // The slot can take a new result when empty or when it is being drained in this same cycle.
    assign can_accept = !resp_valid_q || bus.resp_ready;
    assign any_req    = bus.req0_valid || bus.req1_valid;

    // Pick a winner: a lone requester always wins, a contended cycle goes to prio.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = prio;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    // Ready is a function of valid; with no request neither ready rises.
    assign bus.req0_ready = can_accept && bus.req0_valid && (grant == 1'b0);
    assign bus.req1_ready = can_accept && bus.req1_valid && (grant == 1'b1);

    // Exactly one requester transfers whenever there is space and someone is asking.
    assign xfer = can_accept && any_req;

    // Route the winner's operands into the single ALU.
    always_comb begin
        sel_a  = bus.req0_a;
        sel_b  = bus.req0_b;
        sel_op = bus.req0_op;
        if (grant) begin
            sel_a  = bus.req1_a;
            sel_b  = bus.req1_b;
            sel_op = bus.req1_op;
        end
    end

    // Shared ALU; codes 100-111 are legal and quietly yield zero.
    always_comb begin
        alu_y = '0;
        case (sel_op)
            OP_AND:  alu_y = sel_a & sel_b;
            OP_OR:   alu_y = sel_a | sel_b;
            OP_ADD:  alu_y = sel_a + sel_b;
            OP_SUB:  alu_y = sel_a - sel_b;
            default: alu_y = '0;
        endcase
    end

    // Result slot: load on transfer (also covers pass-through drain), clear valid on a plain drain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= 1'b0;
        end else if (xfer) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= alu_y;
            resp_id_q    <= grant;
        end else if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end

    // Priority flips to the loser only on a transfer, so a stalled pair keeps its order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio <= 1'b0;
        end else if (xfer) begin
            prio <= ~grant;
        end
    end

    // Served-operation counters; wrap silently at 2^CNT_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            served0 <= '0;
            served1 <= '0;
        end else if (xfer) begin
            if (grant) begin
                served1 <= served1 + CNT_ONE;
            end else begin
                served0 <= served0 + CNT_ONE;
            end
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_id    = resp_id_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: directed scenarios plus a randomized phase against a transaction model.
// Latency: model predicts readies each cycle and the result slot one edge later.
// Backpressure: random resp_ready stalls; requesters hold operands until accepted or withdraw.
module tb_alu_rr_arbiter;

    localparam int WIDTH = 32;
    localparam int CNT_W = 2;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [CNT_W-1:0] served0;
    logic [CNT_W-1:0] served1;

    int n_checks = 0;
    int n_errs   = 0;

    // reference model: pending result, who was served last, per-requester tallies
    logic        m_vld;
    logic [31:0] m_data;
    logic        m_id;
    logic        m_last;
    int          m_served [2];
    logic        m_r0;
    logic        m_r1;

    alu_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

    alu_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .served0 (served0),
        .served1 (served1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        longint unsigned s;
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: begin s = longint'(a) + longint'(b); return s[31:0]; end
            3'd3: begin s = longint'(a) + (64'h1_0000_0000 - longint'(b)); return s[31:0]; end
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_vld = 1'b0;
        m_data = '0;
        m_id = 1'b0;
        m_last = 1'b1;      // "requester 1 served last" means requester 0 is favoured
        m_served[0] = 0;
        m_served[1] = 0;
        m_r0 = 1'b0;
        m_r1 = 1'b0;
    endtask

    task automatic drive(input int n, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end
    endtask

    task automatic idle_reqs();
        drive(0, 1'b0, '0, '0, 3'd0);
        drive(1, 1'b0, '0, '0, 3'd0);
    endtask

    // One clock: check readies and visible state at the falling edge, advance the model, cross the rising edge.
    task automatic step();
        logic can;
        logic win;
        @(negedge clk);
        can = !m_vld || bus.resp_ready;
        if (bus.req0_valid && bus.req1_valid) win = !m_last;
        else win = bus.req1_valid;
        m_r0 = can && bus.req0_valid && !win;
        m_r1 = can && bus.req1_valid && win;
        chk("req0_ready", 32'(bus.req0_ready), 32'(m_r0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(m_r1));
        chk("resp_valid", 32'(bus.resp_valid), 32'(m_vld));
        chk("resp_data", bus.resp_data, m_data);
        chk("resp_id", 32'(bus.resp_id), 32'(m_id));
        chk("served0", 32'(served0), 32'(m_served[0]));
        chk("served1", 32'(served1), 32'(m_served[1]));
        if (m_r0 || m_r1) begin
            if (win) m_data = alu_ref(bus.req1_a, bus.req1_b, bus.req1_op);
            else     m_data = alu_ref(bus.req0_a, bus.req0_b, bus.req0_op);
            m_id = win;
            m_vld = 1'b1;
            m_last = win;
            m_served[win] = (m_served[win] + 1) % CNT_MOD;
        end else if (bus.resp_ready) begin
            m_vld = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_reqs();
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        idle_reqs();
        bus.resp_ready = 1'b0;
        model_reset();
        #1;

        // reset then idle
        do_reset();
        step();
        step();

        // single add with overflow into the sign bit
        bus.resp_ready = 1'b1;
        drive(0, 1'b1, 32'h7FFF_FFFF, 32'h1, 3'd2);
        step();
        idle_reqs();
        chk("single_valid", 32'(bus.resp_valid), 32'h1);
        chk("single_data", bus.resp_data, 32'h8000_0000);
        chk("single_served0", 32'(served0), 32'h1);
        step();

        // contention: strict alternation starting at requester 0
        do_reset();
        bus.resp_ready = 1'b1;
        drive(0, 1'b1, 32'd5, 32'd7, 3'd3);
        drive(1, 1'b1, 32'hF0, 32'h0F, 3'd1);
        step();
        chk("alt0_id", 32'(bus.resp_id), 32'h0);
        chk("alt0_data", bus.resp_data, 32'hFFFF_FFFE);
        step();
        chk("alt1_id", 32'(bus.resp_id), 32'h1);
        chk("alt1_data", bus.resp_data, 32'h0000_00FF);
        step();
        step();
        chk("alt_served0", 32'(served0), 32'h2);
        chk("alt_served1", 32'(served1), 32'h2);
        idle_reqs();
        step();

        // backpressure: pending result stalls requester 1, then pass-through drain
        drive(0, 1'b1, 32'd10, 32'd20, 3'd2);
        step();
        idle_reqs();
        bus.resp_ready = 1'b0;
        drive(1, 1'b1, 32'd3, 32'd4, 3'd2);
        repeat (3) step();
        chk("bp_hold_data", bus.resp_data, 32'd30);
        chk("bp_hold_id", 32'(bus.resp_id), 32'h0);
        bus.resp_ready = 1'b1;
        step();
        idle_reqs();
        chk("bp_pass_valid", 32'(bus.resp_valid), 32'h1);
        chk("bp_pass_data", bus.resp_data, 32'd7);
        step();

        // undefined op and counter wrap (CNT_W = 2)
        do_reset();
        bus.resp_ready = 1'b1;
        drive(1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b111);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("wrap_data", bus.resp_data, 32'h0);
            chk("wrap_served1", 32'(served1), 32'((i + 1) % CNT_MOD));
        end
        idle_reqs();
        step();

        // async reset while a result is stalled
        drive(0, 1'b1, 32'd1, 32'd2, 3'd2);
        step();
        idle_reqs();
        bus.resp_ready = 1'b0;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.resp_valid), 32'h0);
        chk("arst_data", bus.resp_data, 32'h0);
        chk("arst_served0", 32'(served0), 32'h0);
        model_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        bus.resp_ready = 1'b1;
        drive(0, 1'b1, 32'd9, 32'd1, 3'd3);
        drive(1, 1'b1, 32'd9, 32'd1, 3'd2);
        #1;
        chk("arst_first_r0", 32'(bus.req0_ready), 32'h1);
        chk("arst_first_r1", 32'(bus.req1_ready), 32'h0);
        step();
        idle_reqs();
        step();

        // randomized traffic with protocol-compliant requesters
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bus.resp_ready = ($urandom_range(99) < 65);
            if (bus.req0_valid && !m_r0) begin
                if ($urandom_range(7) == 0) bus.req0_valid = 1'b0;
            end else begin
                drive(0, ($urandom_range(99) < 60), $urandom, $urandom, 3'($urandom_range(7)));
            end
            if (bus.req1_valid && !m_r1) begin
                if ($urandom_range(7) == 0) bus.req1_valid = 1'b0;
            end else begin
                drive(1, ($urandom_range(99) < 60), $urandom, $urandom, 3'($urandom_range(7)));
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
